// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction-fetch / load-store memory port.
// Holds FSM states, access size codes and the latched command bundle.
package cpu_mem_pkg;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        owner_ls;
        logic        we;
        size_e       size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Unknown size code 3 is checked like a word so it can never slip through.
    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        logic m;
        m = 1'b0;
        unique case (size)
            BYTE:    m = 1'b0;
            HALF:    m = lo[0];
            default: m = |lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; bit 0 = IF, bit 1 = LS.
// The last-served pointer moves only when a grant is issued.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_ls_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (1'b1)
                (req == 2'b11): gnt = last_ls_q ? 2'b01 : 2'b10;
                (req == 2'b01): gnt = 2'b01;
                (req == 2'b10): gnt = 2'b10;
                default:        gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_ls_q <= 1'b1;
        end else if (|gnt) begin
            last_ls_q <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One access in flight; misaligned requests and timeouts end in an error.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e      state_q;
    mem_cmd_t    cmd_q;
    mem_cmd_t    cmd_d;
    logic [CW-1:0] cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [1:0]  gnt;
    logic        arb_en;
    logic        mis_d;
    logic        resp;

    // Gating with reset keeps gnt low while the block is held in reset.
    assign arb_en = reset && (state_q == IDLE);

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .en    (arb_en),
        .req   ({ls_req, if_req}),
        .gnt   (gnt)
    );

    always_comb begin
        cmd_d          = '0;
        cmd_d.owner_ls = gnt[1];
        cmd_d.we       = gnt[1] & ls_we;
        cmd_d.size     = gnt[1] ? size_e'(ls_size) : WORD;
        cmd_d.addr     = gnt[1] ? ls_addr : if_addr;
        cmd_d.wdata    = gnt[1] ? ls_wdata : 32'd0;
    end

    assign mis_d = misaligned(cmd_d.size, cmd_d.addr[1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        cmd_q   <= cmd_d;
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= mis_d;
                        state_q <= mis_d ? ERR : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        rdata_q <= cmd_q.we ? 32'd0 : mem_rdata;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign resp      = (state_q == RESP) || (state_q == ERR);

    assign if_gnt    = gnt[0];
    assign ls_gnt    = gnt[1];

    assign mem_req   = (state_q == WAIT);
    assign mem_we    = cmd_q.we;
    assign mem_size  = cmd_q.size;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    assign if_rvalid = resp & ~cmd_q.owner_ls;
    assign ls_rvalid = resp & cmd_q.owner_ls;
    assign if_err    = if_rvalid & err_q;
    assign ls_err    = ls_rvalid & err_q;
    assign if_rdata  = if_rvalid ? rdata_q : 32'd0;
    assign ls_rdata  = ls_rvalid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences
// and random traffic against a transaction-level reference.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit last_ls;

    mem_port_arbiter #(.TIMEOUT(255)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    typedef struct {
        bit          ls;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          d;
        logic [31:0] rd;
        bit          xerr;
        logic [31:0] xrd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Alignment rule from the access-size definition.
    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return a[0];
        if (sz == 2'd2) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    task automatic chk_resp(input bit xls, input bit xe, input logic [31:0] xr);
        chk("if_rvalid", if_rvalid, !xls);
        chk("ls_rvalid", ls_rvalid, xls);
        chk("if_err", if_err, !xls && xe);
        chk("ls_err", ls_err, xls && xe);
        chk("if_rdata", if_rdata, xls ? 32'd0 : xr);
        chk("ls_rdata", ls_rdata, xls ? xr : 32'd0);
        chk("resp_busy", busy, 1);
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests driven;
    // leaves at posedge+1 of the following IDLE cycle.
    task automatic serve(input bit xls, input int d, input logic [31:0] rd,
                         input bit xerr, input logic [31:0] xrd);
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        we;
        a  = xls ? ls_addr : if_addr;
        sz = xls ? ls_size : 2'd2;
        we = xls ? ls_we : 1'b0;
        wd = ls_wdata;
        #1;
        chk("if_gnt", if_gnt, !xls);
        chk("ls_gnt", ls_gnt, xls);
        chk("idle_busy", busy, 0);
        tick();
        if (xerr) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk_resp(xls, 1'b1, 32'd0);
            chk("err_mem_req", mem_req, 0);
            chk("err_gnt", {30'd0, ls_gnt, if_gnt}, 0);
            tick();
            mem_ack = 1'b0;
        end else begin
            for (int i = 0; i < d; i++) begin
                if (i == d - 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                #1;
                chk("mem_req", mem_req, 1);
                chk("mem_addr", mem_addr, a);
                chk("mem_we", mem_we, we);
                chk("mem_size", mem_size, sz);
                if (we) chk("mem_wdata", mem_wdata, wd);
                chk("wait_rvalid", {30'd0, ls_rvalid, if_rvalid}, 0);
                chk("wait_gnt", {30'd0, ls_gnt, if_gnt}, 0);
                chk("wait_busy", busy, 1);
                tick();
                mem_ack = 1'b0;
            end
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk_resp(xls, 1'b0, xrd);
            chk("resp_mem_req", mem_req, 0);
            tick();
            mem_ack = 1'b0;
        end
    endtask

    vec_t tbl[8];

    initial begin
        bit          pif;
        bit          pls;
        bit          xls;
        bit          mis;
        bit          we;
        int          d;
        int          n;
        logic [31:0] rd;

        tbl = '{
            '{1, 0, 2'd2, 32'h0100_0002, 32'h0,         1, 32'h0,         1, 32'h0},
            '{1, 0, 2'd0, 32'h0100_0003, 32'h0,         2, 32'h0000_00A5, 0, 32'h0000_00A5},
            '{1, 0, 2'd1, 32'h0100_0001, 32'h0,         1, 32'h0,         1, 32'h0},
            '{1, 0, 2'd1, 32'h0100_0006, 32'h0,         1, 32'h0000_1234, 0, 32'h0000_1234},
            '{1, 1, 2'd2, 32'h0100_0010, 32'hCAFE_F00D, 4, 32'h5555_5555, 0, 32'h0},
            '{0, 0, 2'd2, 32'h0100_0021, 32'h0,         1, 32'h0,         1, 32'h0},
            '{0, 0, 2'd2, 32'h0100_0024, 32'h0,         1, 32'h8765_4321, 0, 32'h8765_4321},
            '{1, 1, 2'd1, 32'h0100_0003, 32'h1111_2222, 1, 32'h0,         1, 32'h0}
        };

        reset     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0100_0000;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_size   = 2'd2;
        ls_addr   = 32'h0100_0008;
        ls_wdata  = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        last_ls   = 1'b1;

        repeat (2) tick();
        #1;
        chk("rst_gnt", {30'd0, ls_gnt, if_gnt}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rvalid", {30'd0, ls_rvalid, if_rvalid}, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
        tick();
        reset = 1'b1;

        // Four back-to-back contended accesses alternate starting with IF.
        for (int i = 0; i < 4; i++) begin
            rd = 32'h1000 + 32'(i);
            serve(i[0], 1, rd, 1'b0, rd);
        end
        last_ls = 1'b1;
        if_req  = 1'b0;
        ls_req  = 1'b0;

        if_req  = 1'b1;
        if_addr = 32'h0100_0000;
        serve(1'b0, 3, 32'h0000_0013, 1'b0, 32'h0000_0013);
        if_req  = 1'b0;
        last_ls = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].ls) begin
                ls_req   = 1'b1;
                ls_we    = tbl[i].we;
                ls_size  = tbl[i].size;
                ls_addr  = tbl[i].addr;
                ls_wdata = tbl[i].wdata;
            end else begin
                if_req  = 1'b1;
                if_addr = tbl[i].addr;
            end
            serve(tbl[i].ls, tbl[i].d, tbl[i].rd, tbl[i].xerr, tbl[i].xrd);
            if_req  = 1'b0;
            ls_req  = 1'b0;
            last_ls = tbl[i].ls;
        end

        // Write that is never acknowledged.
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_size  = 2'd2;
        ls_addr  = 32'h0100_0100;
        ls_wdata = 32'hDEAD_BEEF;
        #1;
        chk("to_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0;
        #1;
        n = 0;
        while (mem_req === 1'b1 && n < 300) begin
            if (n == 0) chk("to_wdata", mem_wdata, 32'hDEAD_BEEF);
            n++;
            @(posedge clock);
            #2;
        end
        chk("to_req_cycles", n, 255);
        chk("to_rvalid", ls_rvalid, 1);
        chk("to_err", ls_err, 1);
        chk("to_rdata", ls_rdata, 0);
        chk("to_if_rvalid", if_rvalid, 0);
        tick();
        last_ls = 1'b1;

        // Ack on the last allowed wait cycle beats the timeout.
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0100_0200;
        serve(1'b1, 255, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE);
        ls_req  = 1'b0;
        last_ls = 1'b1;

        pif = 1'b0;
        pls = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!pif && $urandom_range(0, 1) == 1) begin
                pif     = 1'b1;
                if_req  = 1'b1;
                if_addr = $urandom;
                if ($urandom_range(0, 1) == 1) if_addr[1:0] = 2'b00;
            end
            if (!pls && $urandom_range(0, 1) == 1) begin
                pls      = 1'b1;
                ls_req   = 1'b1;
                ls_we    = 1'($urandom_range(0, 1));
                ls_size  = 2'($urandom_range(0, 2));
                ls_addr  = $urandom;
                ls_wdata = $urandom;
                if ($urandom_range(0, 1) == 1) ls_addr[1:0] = 2'b00;
            end
            if (!pif && !pls) begin
                #1;
                chk("rnd_idle_gnt", {30'd0, ls_gnt, if_gnt}, 0);
                chk("rnd_idle_busy", busy, 0);
                tick();
                continue;
            end
            xls = (pif && pls) ? !last_ls : pls;
            d   = $urandom_range(1, 4);
            rd  = $urandom;
            mis = xls ? misal(ls_size, ls_addr) : misal(2'd2, if_addr);
            we  = xls ? ls_we : 1'b0;
            serve(xls, d, rd, mis, (mis || we) ? 32'd0 : rd);
            last_ls = xls;
            if (xls) begin
                pls    = 1'b0;
                ls_req = 1'b0;
            end else begin
                pif    = 1'b0;
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // Reset lands two cycles into WAIT.
        if_req  = 1'b1;
        if_addr = 32'h0100_0040;
        #1;
        chk("ra_gnt", if_gnt, 1);
        tick();
        tick();
        #1;
        chk("ra_mem_req_pre", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ra_mem_req", mem_req, 0);
        chk("ra_busy", busy, 0);
        if_req = 1'b0;
        repeat (2) begin
            tick();
            chk("ra_no_rvalid", {30'd0, ls_rvalid, if_rvalid}, 0);
            chk("ra_no_req", mem_req, 0);
        end
        tick();
        reset   = 1'b1;
        last_ls = 1'b1;

        if_req  = 1'b1;
        if_addr = 32'h0100_0080;
        serve(1'b0, 2, 32'h0000_0777, 1'b0, 32'h0000_0777);
        if_req  = 1'b0;
        last_ls = 1'b0;

        // A fresh reset puts the pointer back on LS, so IF wins.
        tick();
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h0100_0090;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_size = 2'd2;
        ls_addr = 32'h0100_00A0;
        serve(1'b0, 1, 32'h0000_0999, 1'b0, 32'h0000_0999);
        if_req = 1'b0;
        ls_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
